// File: rtl/riscv_pkg.sv
// Shared RV64 pipeline definitions: machine widths, the default reset PC,
// the fetch-queue entry layout and a PC word-alignment helper.
package riscv_pkg;
  localparam int XLEN = 64;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/ifetch_queue.sv
// Fetch queue: a circular buffer of fetch_entry_t.
//   head : oldest entry, presented to decode
//   fill : oldest allocated entry still waiting for its response
//   tail : next free slot
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   flush              drop every entry (wins over alloc/fill/pop)
//   alloc, alloc_pc    allocate an unfilled entry at the tail
//   fill, fill_instr   complete the oldest unfilled entry
//   pop                retire the head entry
//   head               head entry contents (meaningful when occ != 0)
//   occ, unfilled      allocated entries / allocated-but-unfilled entries
module ifetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            alloc,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill,
  input  logic [ILEN-1:0] fill_instr,
  input  logic            pop,
  output fetch_entry_t    head,
  output logic [CW-1:0]   occ,
  output logic [CW-1:0]   unfilled
);

  fetch_entry_t    ents_q [DEPTH];
  fetch_entry_t    ents_d [DEPTH];
  logic [PW-1:0]   head_q, head_d, fill_q, fill_d, tail_q, tail_d;
  logic [CW-1:0]   occ_q, occ_d, unf_q, unf_d;

  assign head     = ents_q[head_q];
  assign occ      = occ_q;
  assign unfilled = unf_q;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    ents_d = ents_q;
    head_d = head_q;
    fill_d = fill_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    unf_d  = unf_q;
    if (flush) begin
      head_d = '0;
      fill_d = '0;
      tail_d = '0;
      occ_d  = '0;
      unf_d  = '0;
    end else begin
      // On a full queue an alloc with a pop reuses the head slot: head is
      // read combinationally before the edge, so both are safe together.
      if (alloc) begin
        ents_d[tail_q] = '{pc: alloc_pc, instr: '0, filled: 1'b0};
        tail_d         = tail_q + PW'(1);
      end
      if (fill) begin
        ents_d[fill_q].instr  = fill_instr;
        ents_d[fill_q].filled = 1'b1;
        fill_d                = fill_q + PW'(1);
      end
      if (pop) head_d = head_q + PW'(1);
      occ_d = occ_q + CW'(alloc) - CW'(pop);
      unf_d = unf_q + CW'(alloc) - CW'(fill);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      fill_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      unf_q  <= '0;
    end else begin
      head_q <= head_d;
      fill_q <= fill_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      unf_q  <= unf_d;
    end
    ents_q <= ents_d;
  end

endmodule

// File: rtl/ifetch.sv
// RV64 instruction-fetch stage. Owns the PC, issues in-order word fetches,
// buffers returned words with their PC and hands {pc, instr} to decode.
// A redirect flushes the queue; responses for fetches already in flight
// are counted in drop_cnt and discarded when they return.
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   imem_req_valid/ready/addr           fetch request channel
//   imem_resp_valid/data                in-order responses, no backpressure
//   redirect_valid, redirect_pc         new PC from branch resolution
//   if_valid/ready, if_pc, if_instr     instruction output to decode
module ifetch
  import riscv_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = riscv_pkg::RESET_PC,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [63:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int CW = $clog2(QUEUE_DEPTH + 1);
  localparam int DW = CW + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [DW-1:0]   drop_q, drop_d;
  logic [DW:0]     busy;
  logic            req_fire, resp_taken, head_live;
  logic            q_alloc, q_fill, q_pop;
  fetch_entry_t    head;
  logic [CW-1:0]   occ, unfilled;

  ifetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .alloc      (q_alloc),
    .alloc_pc   (pc_q),
    .fill       (q_fill),
    .fill_instr (imem_resp_data),
    .pop        (q_pop),
    .head       (head),
    .occ        (occ),
    .unfilled   (unfilled)
  );

  // Every outstanding response needs a home: a queue slot or a drop credit.
  // No credit is taken from a same-cycle pop, so request valid never depends
  // on if_ready and cannot fall while the memory is stalling us.
  assign busy           = (DW+1)'(occ) + (DW+1)'(drop_q);
  assign imem_req_valid = !reset && (busy < (DW+1)'(QUEUE_DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // A legal response consumes either a drop credit or an unfilled entry.
  assign resp_taken = imem_resp_valid && (drop_q != '0 || unfilled != '0);

  assign head_live = !reset && (occ != '0);
  assign if_valid  = head_live && head.filled;
  assign if_pc     = head_live ? head.pc : '0;
  assign if_instr  = head_live ? head.instr : '0;

  always_comb begin
    pc_d    = pc_q;
    drop_d  = drop_q;
    q_alloc = 1'b0;
    q_fill  = 1'b0;
    q_pop   = 1'b0;
    if (redirect_valid) begin
      // Everything in flight becomes stale, including a fetch accepted this
      // cycle; a response arriving now retires one of them immediately.
      pc_d   = word_align(redirect_pc);
      drop_d = drop_q + DW'(unfilled) + DW'(req_fire) - DW'(resp_taken);
    end else begin
      q_alloc = req_fire;
      q_pop   = if_valid && if_ready;
      if (req_fire) pc_d = pc_q + 64'd4;
      if (imem_resp_valid) begin
        if (drop_q != '0)        drop_d = drop_q - DW'(1);
        else if (unfilled != '0) q_fill = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  // A response with nothing outstanding is ignored by the logic above.
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (reset)
    !(imem_resp_valid && drop_q == '0 && unfilled == '0));

endmodule

// File: tb/tb_ifetch.sv
// Randomized bench for ifetch. The memory is a pending-response list with a
// per-request latency; the reference model tracks, per redirect epoch, the
// PCs handed out, how many have returned, and how many stale responses are
// still on their way.
module tb_ifetch;
  localparam int DEPTH = 2;
  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        if_valid, if_ready;
  logic [63:0] if_pc;
  logic [31:0] if_instr;

  ifetch #(.RESET_PC(RST_PC), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, cyc = 0;

  // knobs
  logic rst_now;
  int   ir_mode, rr_mode, lat_lo, lat_hi, rd_mode, rd_prob;
  logic rd_done;

  // reference model
  logic [63:0] m_pc;
  int          epoch;
  logic [63:0] exp_pc[$];
  int          filled_n;
  logic [63:0] pd_addr[$];
  int          pd_ep[$];
  int          pd_due[$];
  int          last_due;

  function automatic logic [31:0] mword(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC;
    epoch++;
    exp_pc.delete();
    filled_n = 0;
    pd_addr.delete();
    pd_ep.delete();
    pd_due.delete();
    last_due = cyc;
  endtask

  task automatic step();
    int   stale, due;
    logic exp_rv, acc, resp, pop, rd;
    logic [63:0] tgt;
    @(negedge clk);
    cyc++;
    reset = rst_now;
    case (ir_mode)
      0:       if_ready = 1'b1;
      1:       if_ready = 1'b0;
      default: if_ready = ($urandom_range(0, 99) < 60);
    endcase
    case (rr_mode)
      0:       imem_req_ready = 1'b1;
      1:       imem_req_ready = cyc[0];
      default: imem_req_ready = ($urandom_range(0, 99) < 70);
    endcase
    if (!rst_now && pd_due.size() > 0 && pd_due[0] <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mword(pd_addr[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    redirect_valid = 1'b0;
    redirect_pc    = {$urandom, $urandom};
    #1;
    stale = 0;
    foreach (pd_ep[i]) if (pd_ep[i] != epoch) stale++;
    exp_rv = !rst_now && (exp_pc.size() + stale < DEPTH);
    rd  = 1'b0;
    tgt = 64'h8000_0000 + 64'($urandom_range(0, 16'hFFFF));
    if (!rst_now) begin
      case (rd_mode)
        1: rd = ($urandom_range(0, 99) < rd_prob);
        2: begin rd = !rd_done && pd_addr.size() >= 2; tgt = 64'h8000_1002; end
        3: rd = !rd_done && imem_req_valid && imem_req_ready && imem_resp_valid;
        default: rd = 1'b0;
      endcase
    end
    if (rd) begin
      rd_done        = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
    end
    #1;
    chk("req_valid", 64'(imem_req_valid), 64'(exp_rv));
    if (rst_now) begin
      chk("rst_if_valid", 64'(if_valid), 64'd0);
      chk("rst_if_pc", if_pc, 64'd0);
      chk("rst_if_instr", 64'(if_instr), 64'd0);
    end else begin
      chk("req_addr", imem_req_addr, m_pc);
      chk("if_valid", 64'(if_valid), 64'(filled_n > 0));
      chk("if_pc", if_pc, exp_pc.size() > 0 ? exp_pc[0] : 64'd0);
      if (filled_n > 0) chk("if_instr", 64'(if_instr), 64'(mword(exp_pc[0])));
    end
    // advance the model across the coming edge
    acc  = imem_req_valid && imem_req_ready;
    resp = imem_resp_valid;
    pop  = if_valid && if_ready;
    if (rst_now) begin
      model_reset();
    end else begin
      if (resp) begin
        if (pd_ep[0] == epoch) filled_n++;
        void'(pd_addr.pop_front());
        void'(pd_ep.pop_front());
        void'(pd_due.pop_front());
      end
      if (acc) begin
        due = cyc + $urandom_range(lat_lo, lat_hi);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pd_addr.push_back(m_pc);
        pd_ep.push_back(epoch);
        pd_due.push_back(due);
      end
      if (rd) begin
        exp_pc.delete();
        filled_n = 0;
        epoch++;
        m_pc = {tgt[63:2], 2'b00};
      end else begin
        if (pop && exp_pc.size() > 0) begin
          void'(exp_pc.pop_front());
          filled_n--;
        end
        if (acc) begin
          exp_pc.push_back(m_pc);
          m_pc = m_pc + 64'd4;
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0;
    imem_resp_data = '0; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    epoch = 0;
    model_reset();
    ir_mode = 0; rr_mode = 0; lat_lo = 1; lat_hi = 1; rd_mode = 0; rd_prob = 0;
    rd_done = 1'b0;

    rst_now = 1'b1; run(3);
    rst_now = 1'b0;
    // in-order fetch after reset release, 1-cycle memory
    run(30);
    // decode stalls: queue fills to depth, then drains in order
    ir_mode = 1; run(5);
    ir_mode = 0; run(10);
    // redirect to a misaligned target with two fetches in flight
    lat_lo = 3; lat_hi = 3; rd_mode = 2; rd_done = 1'b0; run(25);
    // redirect coinciding with an accepted request and a response
    lat_lo = 1; lat_hi = 2; rd_mode = 3; rd_done = 1'b0; run(40);
    rd_mode = 0;
    // request channel toggling, 3-cycle memory
    rr_mode = 1; lat_lo = 3; lat_hi = 3; run(40);
    // reset with a full queue, then restart
    rr_mode = 0; lat_lo = 1; lat_hi = 1; ir_mode = 1; run(8);
    rst_now = 1'b1; run(1);
    rst_now = 1'b0; ir_mode = 0; run(20);
    // everything random
    ir_mode = 2; rr_mode = 2; lat_lo = 1; lat_hi = 4; rd_mode = 1; rd_prob = 8;
    run(400);
    rd_mode = 0; run(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
